// File: rtl/adsr_envelope.sv
// adsr_envelope
//   ADSR amplitude envelope applied to a stream of signed samples. The envelope
//   runs ATTACK -> DECAY -> SUSTAIN -> RELEASE -> IDLE. The note is held for
//   note_duration << DUR_SHIFT samples and then released. Each accepted sample is
//   multiplied by the current envelope level, which is treated as a fraction of
//   full scale, and the result is registered.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   note_start        1-cycle pulse that starts or retriggers a note
//   note_duration     hold length in units of 2^DUR_SHIFT samples, latched on note_start
//   attack_step       level increment per sample in ATTACK
//   decay_step        level decrement per sample in DECAY
//   sustain_level     DECAY target and SUSTAIN hold level
//   release_step      level decrement per sample in RELEASE
//   new_sample_ready  strobe, sample valid this cycle
//   sample            signed input sample
//   final_sample      signed scaled sample (registered)
//   final_valid       1-cycle strobe when final_sample updates
//   env_level         current envelope level
//   env_state         IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   note_done         1-cycle pulse on RELEASE -> IDLE
module adsr_envelope #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ENV_WIDTH    = 8,
    parameter int DUR_WIDTH    = 6,
    parameter int DUR_SHIFT    = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           note_start,
    input  logic [DUR_WIDTH-1:0]           note_duration,
    input  logic [ENV_WIDTH-1:0]           attack_step,
    input  logic [ENV_WIDTH-1:0]           decay_step,
    input  logic [ENV_WIDTH-1:0]           sustain_level,
    input  logic [ENV_WIDTH-1:0]           release_step,
    input  logic                           new_sample_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] sample,
    output logic signed [SAMPLE_WIDTH-1:0] final_sample,
    output logic                           final_valid,
    output logic [ENV_WIDTH-1:0]           env_level,
    output logic [2:0]                     env_state,
    output logic                           note_done
);

    localparam int HOLD_W = DUR_WIDTH + DUR_SHIFT;
    localparam int PROD_W = SAMPLE_WIDTH + ENV_WIDTH + 1;
    localparam logic [ENV_WIDTH-1:0] LEVEL_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic [ENV_WIDTH-1:0]           level_q, level_d;
    logic [HOLD_W-1:0]              hold_cnt_q, hold_cnt_d;
    logic [DUR_WIDTH-1:0]           dur_q, dur_d;
    logic signed [SAMPLE_WIDTH-1:0] final_sample_q, final_sample_d;
    logic                           final_valid_q, final_valid_d;
    logic                           note_done_q, note_done_d;
    logic [HOLD_W-1:0]              hold_len;

    // Level + step, pinned at full scale instead of wrapping.
    function automatic logic [ENV_WIDTH-1:0] sat_add(input logic [ENV_WIDTH-1:0] a,
                                                     input logic [ENV_WIDTH-1:0] b);
        logic [ENV_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[ENV_WIDTH] ? LEVEL_MAX : sum[ENV_WIDTH-1:0];
    endfunction

    // Level - step, never going below floor (borrow also means "below floor").
    function automatic logic [ENV_WIDTH-1:0] clamp_sub(input logic [ENV_WIDTH-1:0] a,
                                                       input logic [ENV_WIDTH-1:0] b,
                                                       input logic [ENV_WIDTH-1:0] floor_lvl);
        logic [ENV_WIDTH:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[ENV_WIDTH] || (diff[ENV_WIDTH-1:0] < floor_lvl))
            return floor_lvl;
        return diff[ENV_WIDTH-1:0];
    endfunction

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    // Full-width signed multiply. Level is zero-extended so it is always positive.
    // |result| < 2^(SAMPLE_WIDTH-1) after the shift, so truncation cannot overflow.
    function automatic logic signed [SAMPLE_WIDTH-1:0] scale(
        input logic signed [SAMPLE_WIDTH-1:0] smp,
        input logic [ENV_WIDTH-1:0]           lvl);
        logic signed [PROD_W-1:0] a_ext, b_ext, prod, shifted;
        a_ext   = PROD_W'(smp);
        b_ext   = PROD_W'($signed({1'b0, lvl}));
        prod    = a_ext * b_ext;
        shifted = prod >>> ENV_WIDTH;
        return $signed(shifted[SAMPLE_WIDTH-1:0]);
    endfunction

    assign hold_len = HOLD_W'(dur_q) << DUR_SHIFT;

    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        hold_cnt_d     = hold_cnt_q;
        dur_d          = dur_q;
        final_sample_d = final_sample_q;
        final_valid_d  = 1'b0;
        note_done_d    = 1'b0;

        // Output path always uses the level from before this cycle's update.
        if (new_sample_ready) begin
            final_valid_d  = 1'b1;
            final_sample_d = (state_q == ST_IDLE) ? '0 : scale(sample, level_q);
        end

        if (note_start) begin
            // Retrigger keeps the current level so there is no audible click.
            dur_d      = note_duration;
            hold_cnt_d = '0;
            state_d    = ST_ATTACK;
        end else if (new_sample_ready) begin
            case (state_q)
                ST_ATTACK: begin
                    level_d = sat_add(level_q, attack_step);
                    if (level_d == LEVEL_MAX)
                        state_d = ST_DECAY;
                end
                ST_DECAY: begin
                    if (level_q <= sustain_level) begin
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = clamp_sub(level_q, decay_step, sustain_level);
                        if (level_d == sustain_level)
                            state_d = ST_SUSTAIN;
                    end
                end
                ST_SUSTAIN: ;
                ST_RELEASE: begin
                    level_d = clamp_sub(level_q, release_step, '0);
                    if (level_d == '0) begin
                        state_d     = ST_IDLE;
                        note_done_d = 1'b1;
                    end
                end
                ST_IDLE: ;
                default: state_d = ST_IDLE;
            endcase

            // Hold expiry overrides any phase transition chosen above; the level
            // step of this sample still applies.
            if (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN) begin
                hold_cnt_d = sat_inc(hold_cnt_q);
                if (hold_cnt_d >= hold_len)
                    state_d = ST_RELEASE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            level_q        <= '0;
            hold_cnt_q     <= '0;
            dur_q          <= '0;
            final_sample_q <= '0;
            final_valid_q  <= 1'b0;
            note_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            hold_cnt_q     <= hold_cnt_d;
            dur_q          <= dur_d;
            final_sample_q <= final_sample_d;
            final_valid_q  <= final_valid_d;
            note_done_q    <= note_done_d;
        end
    end

    assign final_sample = final_sample_q;
    assign final_valid  = final_valid_q;
    assign env_level    = level_q;
    assign env_state    = state_q;
    assign note_done    = note_done_q;

endmodule
